vga_timing_gen: RTL

Parametrised video timing generator: successor to the fixed 640x480 `vga_controller`. It produces sync, blanking and pixel coordinates for any raster geometry, sync polarity and pixel-clock divide ratio, all from a single system clock with a pixel clock-enable. It also emits frame, line and vblank strobes, so `ball`-style motion logic gets a proper one-cycle `frame_clk` enable instead of a derived clock. It sits between the clocking block and `color_mapper`/`hdmi_tx_0`.

---
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock-enable, syncs, blanking, coordinates and frame/line/vblank strobes.
// All outputs registered and mutually aligned; en=0 freezes the raster (no backpressure beyond that).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CE_DIV   = 1,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             pix_ce,
    output logic             hs,
    output logic             vs,
    output logic             active_nblank,
    output logic [CNT_W-1:0] drawX,
    output logic [CNT_W-1:0] drawY,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CE_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CE_W-1:0]  CE_LAST = CE_W'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ON   = 1'(HS_POL);
    localparam logic             VS_ON   = 1'(VS_POL);

    if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for raster totals");
    end
    if (CE_DIV < 1) begin : g_bad_ce_div
        $error("vga_timing_gen: CE_DIV must be >= 1");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_geom
        $error("vga_timing_gen: porch, sync and active counts must be non-zero");
    end

    logic [CE_W-1:0]  ce_cnt_q, ce_cnt_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             pix_ce_q, pix_ce_d;
    logic             hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic             ls_q, ls_d, fs_q, fs_d, vbs_q, vbs_d;
    logic             ce_wrap, adv;

    // The registered decode is taken from the next position so it lines up with drawX/drawY.
    always_comb begin
        ce_wrap       = (ce_cnt_q == CE_LAST);
        ce_cnt_d      = ce_cnt_q;
        pix_ce_d      = en && ce_wrap;
        adv           = pix_ce_q && en;
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;

        if (en) begin
            ce_cnt_d = ce_wrap ? '0 : ce_cnt_q + 1'b1;
        end

        if (adv) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        act_d = (x_d < H_ACT) && (y_d < V_ACT);
        hs_d  = ((x_d >= H_SS) && (x_d < H_SE)) ? HS_ON : ~HS_ON;
        vs_d  = ((y_d >= V_SS) && (y_d < V_SE)) ? VS_ON : ~VS_ON;
        ls_d  = pix_ce_d && (x_d == '0);
        fs_d  = ls_d && (y_d == '0);
        vbs_d = ls_d && (y_d == V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_cnt_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            pix_ce_q      <= 1'b0;
            hs_q          <= ~HS_ON;
            vs_q          <= ~VS_ON;
            act_q         <= 1'b0;
            ls_q          <= 1'b0;
            fs_q          <= 1'b0;
            vbs_q         <= 1'b0;
        end else begin
            ce_cnt_q      <= ce_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            pix_ce_q      <= pix_ce_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            act_q         <= act_d;
            ls_q          <= ls_d;
            fs_q          <= fs_d;
            vbs_q         <= vbs_d;
        end
    end

    assign pix_ce        = pix_ce_q;
    assign hs            = hs_q;
    assign vs            = vs_q;
    assign active_nblank = act_q;
    assign drawX         = x_q;
    assign drawY         = y_q;
    assign line_start    = ls_q;
    assign frame_start   = fs_q;
    assign vblank_start  = vbs_q;
    assign frame_count   = frame_count_q;

endmodule
